// File: rtl/axi_w_order_sequencer.sv
// W-channel sequencer: queues {BIN_ID, OH_ID, len} per issued AW and routes W beats
// from the head entry's target port, one burst at a time, in AW issue order.
module axi_w_order_sequencer #(
    parameter int N_TARG_PORT = 7,
    parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     push_ID_i,
    input  logic [LOG_N_TARG+N_TARG_PORT-1:0]        ID_i,
    input  logic [7:0]                               len_i,
    output logic                                     grant_FIFO_ID_o,
    output logic [$clog2(FIFO_DEPTH):0]              fifo_count_o,
    input  logic [N_TARG_PORT-1:0][AXI_DATA_W-1:0]   wdata_i,
    input  logic [N_TARG_PORT-1:0][AXI_DATA_W/8-1:0] wstrb_i,
    input  logic [N_TARG_PORT-1:0]                   wlast_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]   wuser_i,
    input  logic [N_TARG_PORT-1:0]                   wvalid_i,
    output logic [N_TARG_PORT-1:0]                   wready_o,
    output logic [AXI_DATA_W-1:0]                    wdata_o,
    output logic [AXI_DATA_W/8-1:0]                  wstrb_o,
    output logic                                     wlast_o,
    output logic [AXI_USER_W-1:0]                    wuser_o,
    output logic                                     wvalid_o,
    input  logic                                     wready_i,
    output logic                                     len_err_o
);

    localparam int ID_W   = LOG_N_TARG + N_TARG_PORT;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int STRB_W = AXI_DATA_W / 8;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ROUTE = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         beat_q, beat_d;
    logic               len_err_q, len_err_d;
    logic [ID_W-1:0]    id_mem_q  [FIFO_DEPTH];
    logic [7:0]         len_mem_q [FIFO_DEPTH];

    logic [ID_W-1:0]        head_id_s;
    logic [LOG_N_TARG-1:0]  head_bin_s;
    logic [N_TARG_PORT-1:0] head_oh_s;
    logic [7:0]             head_len_s;
    logic                   push_ok_s, hs_s, pop_s;
    logic                   sel_valid_s, sel_last_s;
    logic [AXI_DATA_W-1:0]  sel_data_s;
    logic [STRB_W-1:0]      sel_strb_s;
    logic [AXI_USER_W-1:0]  sel_user_s;

    assign head_id_s       = id_mem_q[rd_q];
    assign head_bin_s      = head_id_s[ID_W-1:N_TARG_PORT];
    assign head_oh_s       = head_id_s[N_TARG_PORT-1:0];
    assign head_len_s      = len_mem_q[rd_q];
    assign grant_FIFO_ID_o = !rst && (count_q != CNT_W'(FIFO_DEPTH));
    assign push_ok_s       = push_ID_i && grant_FIFO_ID_o;
    assign hs_s            = wvalid_o && wready_i;
    assign pop_s           = hs_s && wlast_o;
    assign fifo_count_o    = count_q;
    assign len_err_o       = len_err_q;

    // Select the head entry's target-port payload by its binary index.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_last_s  = 1'b0;
        sel_data_s  = '0;
        sel_strb_s  = '0;
        sel_user_s  = '0;
        for (int p = 0; p < N_TARG_PORT; p++) begin
            sel_valid_s = sel_valid_s | ((head_bin_s == LOG_N_TARG'(p)) & wvalid_i[p]);
            sel_last_s  = sel_last_s  | ((head_bin_s == LOG_N_TARG'(p)) & wlast_i[p]);
            sel_data_s  = sel_data_s  | ({AXI_DATA_W{head_bin_s == LOG_N_TARG'(p)}} & wdata_i[p]);
            sel_strb_s  = sel_strb_s  | ({STRB_W{head_bin_s == LOG_N_TARG'(p)}} & wstrb_i[p]);
            sel_user_s  = sel_user_s  | ({AXI_USER_W{head_bin_s == LOG_N_TARG'(p)}} & wuser_i[p]);
        end
    end

    // Drive the routed beat only while a head entry is active; zero otherwise.
    always_comb begin
        wvalid_o = 1'b0;
        wlast_o  = 1'b0;
        wdata_o  = '0;
        wstrb_o  = '0;
        wuser_o  = '0;
        wready_o = '0;
        if (state_q == ST_ROUTE) begin
            wvalid_o = sel_valid_s;
            wlast_o  = sel_last_s;
            wdata_o  = sel_data_s;
            wstrb_o  = sel_strb_s;
            wuser_o  = sel_user_s;
            wready_o = head_oh_s & {N_TARG_PORT{wready_i}};
        end else begin
            wvalid_o = 1'b0;
        end
    end

    // Next-state for the queue, FSM, beat counter and length check.
    always_comb begin
        state_d   = state_q;
        wr_d      = push_ok_s ? wr_q + PTR_W'(1) : wr_q;
        rd_d      = pop_s ? rd_q + PTR_W'(1) : rd_q;
        count_d   = count_q;
        beat_d    = beat_q;
        len_err_d = hs_s && (wlast_o ? (beat_q != head_len_s) : (beat_q == head_len_s));
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        case (state_q)
            ST_IDLE:  state_d = push_ok_s ? ST_ROUTE : ST_IDLE;
            ST_ROUTE: state_d = (pop_s && (count_q == CNT_W'(1)) && !push_ok_s) ? ST_IDLE : ST_ROUTE;
            default:  state_d = ST_IDLE;
        endcase
        // Counter holds at 255 so an overlong burst still reports an error rather than wrapping.
        if (pop_s) begin
            beat_d = 8'd0;
        end else if (hs_s) begin
            beat_d = (beat_q == 8'hFF) ? 8'hFF : beat_q + 8'd1;
        end else begin
            beat_d = beat_q;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            beat_q    <= 8'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            beat_q    <= beat_d;
            len_err_q <= len_err_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            id_mem_q[wr_q]  <= ID_i;
            len_mem_q[wr_q] <= len_i;
        end
    end

endmodule

// File: doc/axi_w_order_sequencer.md
Name: axi_w_order_sequencer

Overview:
- Write-data channel scheduler for one AXI master port of the node.
- Takes one {BIN_ID, OH_ID} entry, plus burst length, from the AW allocator's push interface for each write address it issues.
- Queues the entries in issue order and routes W beats from the granted target port to the master port, one full burst at a time, in exactly AW issue order.
- Pops the head entry on the handshake of its last beat and flags bursts whose WLAST position disagrees with AWLEN.

Parameters:
- N_TARG_PORT, 7, number of slave-side target ports feeding this master port.
- LOG_N_TARG, $clog2(N_TARG_PORT), binary port-index width.
- AXI_DATA_W, 64, W data width; AXI_DATA_W/8 strobe bits.
- AXI_USER_W, 6, wuser width.
- FIFO_DEPTH, 4, outstanding AW entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- push_ID_i  in  1  enqueue request from the AW allocator.
- ID_i  in  LOG_N_TARG+N_TARG_PORT  {BIN_ID, OH_ID} of the granted port.
- len_i  in  8  awlen of the pushed write.
- grant_FIFO_ID_o  out  1  queue can accept a push.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  entries held.
- wdata_i  in  N_TARG_PORT x AXI_DATA_W  per-port W data.
- wstrb_i  in  N_TARG_PORT x AXI_DATA_W/8  per-port W strobes.
- wlast_i  in  N_TARG_PORT  per-port W last.
- wuser_i  in  N_TARG_PORT x AXI_USER_W  per-port W user.
- wvalid_i  in  N_TARG_PORT  per-port W valid.
- wready_o  out  N_TARG_PORT  per-port W ready.
- wdata_o / wstrb_o / wlast_o / wuser_o  out  AXI_DATA_W / AXI_DATA_W/8 / 1 / AXI_USER_W  routed beat.
- wvalid_o  out  1  routed valid.
- wready_i  in  1  master-side ready.
- len_err_o  out  1  one-cycle pulse on a burst-length violation.

Behaviour:
- Reset: synchronous, active-high, clk domain only. Any cycle with rst=1 clears the FIFO, read/write pointers, beat counter and len_err_o.
  - While rst=1, grant_FIFO_ID_o=0.
  - One cycle after rst falls, fifo_count_o=0 and grant_FIFO_ID_o=1.
  - wvalid_o=0, wready_o=0 and all routed data outputs are 0 whenever the FIFO is empty, which includes after reset.
  - Reset mid-burst drops all queued and in-flight bursts; no pop and no error pulse are generated.
- Queue:
  - grant_FIFO_ID_o = !full.
  - A push is accepted when push_ID_i && grant_FIFO_ID_o. It stores {ID_i, len_i} at the write pointer.
  - push_ID_i while full is ignored; no entry is written.
  - No bypass: an entry pushed in cycle t can route beats from cycle t+1 at the earliest.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full and popping: grant stays 0 that cycle; space becomes visible the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count_o ranges 0..FIFO_DEPTH.
- Routing (combinational from head entry H, only when non-empty):
  - wvalid_o = wvalid_i[H.BIN].
  - W payload outputs = port H.BIN's payload.
  - wready_o = H.OH & {N_TARG_PORT{wready_i}}. Non-selected ports always see wready=0.
  - Zero added latency, no buffering of beats.
- States: IDLE (empty) and ROUTE (non-empty, head active).
  - IDLE->ROUTE when an entry is written.
  - ROUTE->IDLE on a last-beat handshake with count=1 and no simultaneous push.
  - Otherwise ROUTE moves to the next entry in the next cycle.
- Beat counter (8-bit, per burst):
  - Reset to 0 on every pop.
  - Incremented on each handshake (wvalid_o && wready_i) with wlast_o=0.
  - Saturates at 255.
- Pop: on a handshake with wlast_o=1, regardless of the counter value.
- len_err_o: registered, asserted for one cycle following the handshake that violates either rule:
  - wlast_o=1 with counter != H.len (early or late WLAST; the pop still happens);
  - wlast_o=0 with counter == H.len (missing WLAST; routing continues on the same head until WLAST arrives).
- Back-to-back bursts from the same or different ports need no bubble: a pop in cycle t means the new head routes in cycle t+1.

Test Plan:
- Push port 2 (ID_i={3'd2,7'b0000100}, len 3); port 2 sends 4 beats with wlast on beat 4 and wready_i=1 -> 4 beats on the output with data from port 2, wready_o=7'b0000100, pop after beat 4, fifo_count_o 1->0, len_err_o never set.
- Push ports 5 then 1, each len 0; both ports hold wvalid with single-beat bursts -> port 5's beat is output in cycle t, port 1's beat in cycle t+1, and port 1 sees wready=0 while port 5 is at the head.
- Push 4 entries (FIFO_DEPTH=4) with no W traffic -> grant_FIFO_ID_o=0 and fifo_count_o=4; a 5th push is dropped. Completing one burst with a simultaneous push keeps the count at 4 for that cycle and grant returns the next cycle.
- len 1, port asserts wlast on beat 1 -> pop occurs and len_err_o pulses 1 cycle after that beat. Next case: len 0 with wlast=0 on beat 1 -> len_err_o pulses, head retained, pop occurs on the later wlast beat.
- Assert rst mid-burst with 3 entries queued -> next cycle fifo_count_o=0, wvalid_o=0, wready_o=0; grant_FIFO_ID_o is 0 while rst=1 and 1 after rst falls; a subsequent push routes normally.
